// File: rtl/bootprom_ctl.sv
// Read controller for a pair of 27256 boot PROMs (high/low byte) with a
// one-word read cache; all outputs registered, timing set by parameters.
module bootprom_ctl #(
  parameter int ACCESS_CYCLES  = 4,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [14:0] addr,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [14:0] prom_a,
  output logic        prom_ce_n,
  output logic        prom_oe_n,
  input  logic [7:0]  prom_d_h,
  input  logic [7:0]  prom_d_l
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    LATCH   = 3'd3,
    HIT     = 3'd4,
    RECOVER = 3'd5,
    WAITREL = 3'd6
  } state_t;

  // Counters run from N-1 down to 0 so a state lasts exactly N clocks.
  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [15:0] cache_data_r;
  logic [14:0] cache_addr_r;
  logic        cache_valid_r;

  // Access sequencer; PROM strobes are set on the transition into each state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      cache_data_r  <= 16'd0;
      cache_addr_r  <= 15'd0;
      cache_valid_r <= 1'b0;
      rdata         <= 16'd0;
      ack           <= 1'b0;
      busy          <= 1'b0;
      prom_a        <= 15'd0;
      prom_ce_n     <= 1'b1;
      prom_oe_n     <= 1'b1;
    end else begin
      ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (cache_valid_r && (addr == cache_addr_r)) begin
              state_r <= HIT;
            end else begin
              state_r   <= SETUP;
              prom_a    <= addr;
              prom_ce_n <= 1'b0;
              prom_oe_n <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        SETUP: begin
          state_r   <= ACCESS;
          cnt_r     <= ACC_LOAD;
          prom_ce_n <= 1'b0;
          prom_oe_n <= 1'b0;
        end
        ACCESS: begin
          if (cnt_r == 4'd0) begin
            state_r   <= LATCH;
            prom_oe_n <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        LATCH: begin
          cache_data_r  <= {prom_d_h, prom_d_l};
          cache_addr_r  <= prom_a;
          cache_valid_r <= 1'b1;
          rdata         <= {prom_d_h, prom_d_l};
          ack           <= 1'b1;
          state_r       <= RECOVER;
          cnt_r         <= REC_LOAD;
          prom_ce_n     <= 1'b1;
          prom_oe_n     <= 1'b1;
        end
        RECOVER: begin
          if (cnt_r == 4'd0) begin
            state_r <= WAITREL;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        HIT: begin
          rdata   <= cache_data_r;
          ack     <= 1'b1;
          state_r <= WAITREL;
        end
        WAITREL: begin
          if (!req) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          prom_ce_n <= 1'b1;
          prom_oe_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bootprom_ctl.sv
// Scoreboard bench for bootprom_ctl: directed reads against a PROM model,
// plus two extra instances exercising the ACCESS_CYCLES extremes.
module tb_bootprom_ctl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [14:0] addr = 15'd0;
  logic [15:0] rdata;
  logic        ack, busy, prom_ce_n, prom_oe_n;
  logic [14:0] prom_a;
  logic [7:0]  prom_d_h, prom_d_l;

  logic        reqx = 1'b0;
  logic [14:0] addrx = 15'd0;
  logic [15:0] rdata1, rdata15;
  logic        ack1, ack15, busy1, busy15, ce1, ce15, oe1, oe15;
  logic [14:0] pa1, pa15;
  logic [7:0]  dh1, dl1, dh15, dl15;

  int cyc = 0, total = 0, fails = 0;
  int ce_low_n = 0, oe_low_n = 0, bad_pins = 0, ack_n = 0;

  typedef struct {
    logic [15:0] data;
    int          issue;
    int          lat;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // PROM model: high byte = A[14:7], low byte = A[7:0] + 0x10; bus floats high when deselected.
  function automatic logic [7:0] model_hi(input logic [14:0] a, input logic ce_n);
    return ce_n ? 8'hFF : a[14:7];
  endfunction
  function automatic logic [7:0] model_lo(input logic [14:0] a, input logic ce_n);
    return ce_n ? 8'hFF : (a[7:0] + 8'h10);
  endfunction

  assign prom_d_h = model_hi(prom_a, prom_ce_n);
  assign prom_d_l = model_lo(prom_a, prom_ce_n);
  assign dh1  = model_hi(pa1, ce1);
  assign dl1  = model_lo(pa1, ce1);
  assign dh15 = model_hi(pa15, ce15);
  assign dl15 = model_lo(pa15, ce15);

  bootprom_ctl dut (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .rdata(rdata), .ack(ack),
    .busy(busy), .prom_a(prom_a), .prom_ce_n(prom_ce_n), .prom_oe_n(prom_oe_n),
    .prom_d_h(prom_d_h), .prom_d_l(prom_d_l)
  );

  bootprom_ctl #(.ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(reqx), .addr(addrx), .rdata(rdata1), .ack(ack1),
    .busy(busy1), .prom_a(pa1), .prom_ce_n(ce1), .prom_oe_n(oe1),
    .prom_d_h(dh1), .prom_d_l(dl1)
  );

  bootprom_ctl #(.ACCESS_CYCLES(15)) dut15 (
    .clk(clk), .reset_n(reset_n), .req(reqx), .addr(addrx), .rdata(rdata15), .ack(ack15),
    .busy(busy15), .prom_a(pa15), .prom_ce_n(ce15), .prom_oe_n(oe15),
    .prom_d_h(dh15), .prom_d_l(dl15)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pin statistics and scoreboard pop on every ack pulse.
  always @(negedge clk) begin
    if (!prom_ce_n) ce_low_n++;
    if (!prom_oe_n) oe_low_n++;
    if (!prom_oe_n && prom_ce_n) bad_pins++;
    if (ack) begin
      ack_n++;
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rdata", int'(rdata), int'(mon_e.data));
        chk("ack_latency", cyc - mon_e.issue, mon_e.lat);
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic do_read(input logic [14:0] a, input logic [15:0] exp_d, input int exp_lat,
                         input int exp_ce_low, input int hold, input bit wiggle,
                         input bit early_drop);
    int a0, k;
    wait_idle();
    ce_low_n = 0;
    oe_low_n = 0;
    a0 = ack_n;
    addr = a;
    req = 1'b1;
    sbq.push_back('{exp_d, cyc, exp_lat});
    for (k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (early_drop) req = 1'b0;
      if (wiggle && k == 2) addr = 15'h1234;
      if (ack_n != a0) break;
    end
    chk("ack_seen", int'(ack_n != a0), 1);
    chk("ce_low_cycles", ce_low_n, exp_ce_low);
    chk("oe_low_cycles", oe_low_n, (exp_ce_low == 0) ? 0 : exp_ce_low - 2);
    if (exp_ce_low != 0) chk("prom_a", int'(prom_a), int'(a));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk); #1;
      end
      chk("busy_while_held", int'(busy), 1);
      chk("single_ack", ack_n - a0, 1);
      req = 1'b0;
      @(negedge clk); #1;
      chk("busy_after_release", int'(busy), 0);
    end
    req = 1'b0;
  endtask

  initial begin
    int a0, k, l1, l15;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pins", int'({prom_ce_n, prom_oe_n}), 3);
    chk("rst_prom_a", int'(prom_a), 0);
    reset_n = 1'b1;

    do_read(15'h0000, 16'h0010, 7, 6, 0, 1'b0, 1'b0);   // first read after reset: miss
    do_read(15'h0000, 16'h0010, 2, 0, 0, 1'b0, 1'b0);   // cached: hit, no PROM activity
    do_read(15'h7FFF, 16'hFF0F, 7, 6, 0, 1'b0, 1'b0);
    do_read(15'h0001, 16'h0011, 7, 6, 0, 1'b1, 1'b0);   // addr wiggled mid-access
    do_read(15'h0001, 16'h0011, 2, 0, 18, 1'b0, 1'b0);  // req held ~20 clocks
    do_read(15'h0100, 16'h0210, 7, 6, 0, 1'b0, 1'b1);   // req dropped early
    do_read(15'h0100, 16'h0210, 2, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of ACCESS.
    wait_idle();
    a0 = ack_n;
    addr = 15'h0002;
    req = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    chk("mid_access_oe", int'(prom_oe_n), 0);
    reset_n = 1'b0;
    #1;
    chk("abort_pins", int'({prom_ce_n, prom_oe_n}), 3);
    chk("abort_busy", int'(busy), 0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1;
    chk("abort_no_ack", ack_n - a0, 0);
    do_read(15'h0002, 16'h0012, 7, 6, 0, 1'b0, 1'b0);   // cache was cleared: miss

    // ACCESS_CYCLES extremes.
    @(negedge clk); #1;
    addrx = 15'h0000;
    reqx = 1'b1;
    l1 = -1;
    l15 = -1;
    a0 = cyc;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack1) begin
        l1 = cyc - a0;
        chk("rdata_ac1", int'(rdata1), 16'h0010);
      end
      if (ack15) begin
        l15 = cyc - a0;
        chk("rdata_ac15", int'(rdata15), 16'h0010);
      end
      if (l15 >= 0) break;
    end
    #1;
    reqx = 1'b0;
    chk("latency_ac1", l1, 4);
    chk("latency_ac15", l15, 18);

    repeat (4) @(negedge clk);
    chk("pin_rule", bad_pins, 0);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks expected completion", total);
    $fatal(1);
  end

endmodule
